jpeg_raster2block: RTL and testbench

- Upstream stage of the JPEG encoder wrapper: accepts raster-order RGB pixels and reorders them into 8x8 blocks of 64 words.
- Uses a ping-pong pair of 8-line strip buffers, so one strip fills while the other drains block by block.
- Output is a valid/ready word stream that the bus master converts one-for-one into encoder FIFO writes. It carries a last-block flag, which the master maps to write address bit 8.

---
 rtl/jpeg_r2b_pkg.sv | 32 +++
 rtl/jpeg_strip_ram.sv | 22 ++
 rtl/jpeg_raster2block.sv | 251 +++++++++++++++++++++++++
 tb/tb_jpeg_raster2block.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_r2b_pkg.sv
// Shared types and geometry for the raster-to-block reorder stage.
package jpeg_r2b_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int unsigned BLK_DIM        = 8;
  localparam int unsigned BLK_PIX        = BLK_DIM * BLK_DIM;
  localparam int unsigned PIX_BITS       = 24;
  localparam int unsigned MAX_WIDTH_DFLT = 256;

  // Column index width inside one strip line.
  function automatic int unsigned col_addr_w(input int unsigned max_width);
    return $clog2(max_width);
  endfunction

  // Strip RAM address width: two banks of BLK_DIM lines of max_width pixels.
  function automatic int unsigned ram_addr_w(input int unsigned max_width);
    return $clog2(2 * BLK_DIM * max_width);
  endfunction

  typedef struct packed {
    logic sob;
    logic last;
    logic fin;
  } beat_meta_t;

  typedef struct packed {
    logic [PIX_BITS-1:0] pix;
    beat_meta_t          meta;
  } beat_t;

endpackage

// File: rtl/jpeg_strip_ram.sv
// 1W/1R synchronous strip buffer RAM with registered read data.
module jpeg_strip_ram #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 24
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/jpeg_raster2block.sv
// Reorders raster RGB pixels into 8x8 blocks through ping-pong 8-line strip banks.
module jpeg_raster2block
  import jpeg_r2b_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = MAX_WIDTH_DFLT,
  parameter int unsigned PIX_W     = PIX_BITS
) (
  input  logic                                 clk,
  input  logic                                 rst_ni,
  input  logic                                 cfg_start,
  input  logic [$clog2(MAX_WIDTH/BLK_DIM):0]   cfg_width_blk,
  input  logic [7:0]                           cfg_height_blk,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 cfg_err,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [PIX_W-1:0]                     in_pixel,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [31:0]                          out_data,
  output logic                                 out_sob,
  output logic                                 out_last_block
);

  localparam int unsigned COL_W = col_addr_w(MAX_WIDTH);
  localparam int unsigned BX_W  = COL_W - $clog2(BLK_DIM);
  localparam int unsigned WB_W  = BX_W + 1;
  localparam int unsigned AW    = ram_addr_w(MAX_WIDTH);

  state_t            state_q, state_d;
  logic [WB_W-1:0]   cfg_w_q, cfg_w_d;
  logic [7:0]        cfg_h_q, cfg_h_d;
  logic [COL_W-1:0]  wcol_q, wcol_d;
  logic [2:0]        wrow_q, wrow_d;
  logic [8:0]        wstrip_q, wstrip_d;
  logic              wbank_q, wbank_d;
  logic [1:0]        full_q, full_d;
  logic [BX_W-1:0]   rbx_q, rbx_d;
  logic [2:0]        rr_q, rr_d, rc_q, rc_d;
  logic [7:0]        rstrip_q, rstrip_d;
  logic              rbank_q, rbank_d;
  logic              inflight_q;
  beat_meta_t        meta_q, meta_d;
  beat_t             head_q, head_d, tail_q, tail_d, new_beat;
  logic              head_v_q, head_v_d, tail_v_q, tail_v_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d, in_ready_q, in_ready_d;

  logic              wr_fire, rd_go, pop, push, cfg_ok, last_blk;
  logic [COL_W-1:0]  wcol_last;
  logic [BX_W-1:0]   bx_last;
  logic [PIX_W-1:0]  rdata;

  assign cfg_ok    = (cfg_width_blk != '0) && (cfg_width_blk <= WB_W'(MAX_WIDTH / BLK_DIM))
                     && (cfg_height_blk != 8'd0);
  assign wcol_last = COL_W'({cfg_w_q, 3'b000} - (COL_W+1)'(1));
  assign bx_last   = BX_W'(cfg_w_q - WB_W'(1));
  assign last_blk  = (rstrip_q == (cfg_h_q - 8'd1)) && (rbx_q == bx_last);

  jpeg_strip_ram #(.AW(AW), .DW(PIX_W)) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr ({wbank_q, wrow_q, wcol_q}),
    .wdata (in_pixel),
    .re    (rd_go),
    .raddr ({rbank_q, rr_q, rbx_q, rc_q}),
    .rdata (rdata)
  );

  // Next-state for control FSM, write/read counters and the output skid buffer.
  always_comb begin
    state_d   = state_q;
    cfg_w_d   = cfg_w_q;
    cfg_h_d   = cfg_h_q;
    wcol_d    = wcol_q;
    wrow_d    = wrow_q;
    wstrip_d  = wstrip_q;
    wbank_d   = wbank_q;
    full_d    = full_q;
    rbx_d     = rbx_q;
    rr_d      = rr_q;
    rc_d      = rc_q;
    rstrip_d  = rstrip_q;
    rbank_d   = rbank_q;
    meta_d    = meta_q;
    head_d    = head_q;
    tail_d    = tail_q;
    head_v_d  = head_v_q;
    tail_v_d  = tail_v_q;
    err_d     = 1'b0;
    done_d    = 1'b0;
    wr_fire   = 1'b0;
    rd_go     = 1'b0;
    pop       = head_v_q && out_ready;
    push      = inflight_q;
    new_beat.pix  = PIX_BITS'(rdata);
    new_beat.meta = meta_q;

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_ok) begin
            state_d  = RUN;
            cfg_w_d  = cfg_width_blk;
            cfg_h_d  = cfg_height_blk;
            wcol_d   = '0;
            wrow_d   = '0;
            wstrip_d = '0;
            wbank_d  = 1'b0;
            full_d   = '0;
            rbx_d    = '0;
            rr_d     = '0;
            rc_d     = '0;
            rstrip_d = '0;
            rbank_d  = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        wr_fire = in_valid && in_ready_q;
        if (wr_fire) begin
          if (wcol_q == wcol_last) begin
            wcol_d = '0;
            wrow_d = wrow_q + 3'd1;
            if (wrow_q == 3'd7) begin
              full_d[wbank_q] = 1'b1;
              wbank_d         = ~wbank_q;
              wstrip_d        = wstrip_q + 9'd1;
            end
          end else begin
            wcol_d = wcol_q + COL_W'(1);
          end
        end

        // A same-cycle pop frees a slot, which keeps the stream at one word per cycle.
        rd_go = full_q[rbank_q] &&
                ((3'(head_v_q) + 3'(tail_v_q) + 3'(inflight_q)) < (3'd2 + 3'(pop)));
        if (rd_go) begin
          meta_d.sob  = (rr_q == 3'd0) && (rc_q == 3'd0);
          meta_d.last = last_blk;
          meta_d.fin  = last_blk && (rr_q == 3'd7) && (rc_q == 3'd7);
          rc_d = rc_q + 3'd1;
          if (rc_q == 3'd7) begin
            rr_d = rr_q + 3'd1;
            if (rr_q == 3'd7) begin
              if (rbx_q == bx_last) begin
                rbx_d           = '0;
                full_d[rbank_q] = 1'b0;
                rbank_d         = ~rbank_q;
                rstrip_d        = rstrip_q + 8'd1;
              end else begin
                rbx_d = rbx_q + BX_W'(1);
              end
            end
          end
        end

        if (pop && head_q.meta.fin) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    endcase

    if (pop) begin
      if (tail_v_q) begin
        head_d   = tail_q;
        tail_v_d = push;
        if (push) tail_d = new_beat;
      end else begin
        head_v_d = push;
        if (push) head_d = new_beat;
      end
    end else if (push) begin
      if (!head_v_q) begin
        head_d   = new_beat;
        head_v_d = 1'b1;
      end else begin
        tail_d   = new_beat;
        tail_v_d = 1'b1;
      end
    end

    busy_d     = (state_d == RUN);
    in_ready_d = (state_d == RUN) && !full_d[wbank_d] && (wstrip_d < {1'b0, cfg_h_d});
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cfg_w_q    <= '0;
      cfg_h_q    <= '0;
      wcol_q     <= '0;
      wrow_q     <= '0;
      wstrip_q   <= '0;
      wbank_q    <= 1'b0;
      full_q     <= '0;
      rbx_q      <= '0;
      rr_q       <= '0;
      rc_q       <= '0;
      rstrip_q   <= '0;
      rbank_q    <= 1'b0;
      inflight_q <= 1'b0;
      meta_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      head_v_q   <= 1'b0;
      tail_v_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_w_q    <= cfg_w_d;
      cfg_h_q    <= cfg_h_d;
      wcol_q     <= wcol_d;
      wrow_q     <= wrow_d;
      wstrip_q   <= wstrip_d;
      wbank_q    <= wbank_d;
      full_q     <= full_d;
      rbx_q      <= rbx_d;
      rr_q       <= rr_d;
      rc_q       <= rc_d;
      rstrip_q   <= rstrip_d;
      rbank_q    <= rbank_d;
      inflight_q <= rd_go;
      meta_q     <= meta_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      head_v_q   <= head_v_d;
      tail_v_q   <= tail_v_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign cfg_err        = err_q;
  assign in_ready       = in_ready_q;
  assign out_valid      = head_v_q;
  assign out_data       = 32'(head_q.pix);
  assign out_sob        = head_q.meta.sob;
  assign out_last_block = head_q.meta.last;

endmodule

// File: tb/tb_jpeg_raster2block.sv
// Directed bench for jpeg_raster2block: block ordering, flags, backpressure, config errors, reset.
module tb_jpeg_raster2block;
  import jpeg_r2b_pkg::*;

  localparam int BP    = BLK_PIX;
  localparam int LIMIT = 20000;

  logic        clk            = 1'b0;
  logic        rst_ni         = 1'b0;
  logic        cfg_start      = 1'b0;
  logic [5:0]  cfg_width_blk  = '0;
  logic [7:0]  cfg_height_blk = '0;
  logic        busy, done, cfg_err;
  logic        in_valid       = 1'b0;
  logic        in_ready;
  logic [23:0] in_pixel       = '0;
  logic        out_valid;
  logic        out_ready      = 1'b0;
  logic [31:0] out_data;
  logic        out_sob, out_last_block;

  int total = 0;
  int bad   = 0;

  jpeg_raster2block #(.MAX_WIDTH(256), .PIX_W(24)) dut (
    .clk            (clk),
    .rst_ni         (rst_ni),
    .cfg_start      (cfg_start),
    .cfg_width_blk  (cfg_width_blk),
    .cfg_height_blk (cfg_height_blk),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pixel       (in_pixel),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_sob        (out_sob),
    .out_last_block (out_last_block)
  );

  always #5 clk = ~clk;

  task automatic start_frame(input int w, input int h);
    cfg_width_blk  = 6'(w);
    cfg_height_blk = 8'(h);
    cfg_start      = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  // Streams a raster frame (pixel = salt ^ raster index) and checks every output beat.
  task automatic run_frame(input int w, input int h, input logic [23:0] salt,
                           input int rdy_pct, input bit poke, output int stalls);
    int npix = w * h * BP;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    bit fin  = 1'b0;
    int s, rem, bx, rr, rc, x, y;
    logic [31:0] exp_d;
    logic [1:0]  exp_f;
    stalls = 0;
    start_frame(w, h);
    while (!fin && cyc < LIMIT) begin
      in_valid  = (sent < npix);
      in_pixel  = salt ^ 24'(sent);
      out_ready = (int'($urandom_range(99)) < rdy_pct);
      cfg_start = 1'b0;
      if (poke && cyc == 20) begin
        cfg_width_blk = 6'd1; cfg_height_blk = 8'd1; cfg_start = 1'b1;
      end
      if (poke && cyc == 40) begin
        cfg_width_blk = 6'd0; cfg_height_blk = 8'd0; cfg_start = 1'b1;
      end
      total++;
      if ({busy, done, cfg_err} !== 3'b100) begin
        bad++;
        $display("FAIL status cyc=%0d got=%b exp=100", cyc, {busy, done, cfg_err});
      end
      if (in_valid && !in_ready) begin
        stalls++;
        total++;
        if ((sent / (w * BP)) - (got / (w * BP)) < 2) begin
          bad++;
          $display("FAIL stall_early cyc=%0d strips_in=%0d strips_out=%0d need_gap=2",
                   cyc, sent / (w * BP), got / (w * BP));
        end
      end
      if (out_valid && out_ready) begin
        s   = got / (w * BP);
        rem = got % (w * BP);
        bx  = rem / BP;
        rr  = (rem % BP) / 8;
        rc  = rem % 8;
        x   = bx * 8 + rc;
        y   = s * 8 + rr;
        exp_d = {8'h00, salt ^ 24'(y * w * 8 + x)};
        exp_f = {(rr == 0 && rc == 0), (s == h - 1 && bx == w - 1)};
        total++;
        if (out_data !== exp_d) begin
          bad++;
          $display("FAIL beat_data w=%0d h=%0d beat=%0d got=%h exp=%h", w, h, got, out_data, exp_d);
        end
        total++;
        if ({out_sob, out_last_block} !== exp_f) begin
          bad++;
          $display("FAIL beat_flags w=%0d h=%0d beat=%0d got=%b exp=%b", w, h, got,
                   {out_sob, out_last_block}, exp_f);
        end
        got++;
        if (got == npix) fin = 1'b1;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    cfg_start = 1'b0;
    total++;
    if (!fin) begin
      bad++;
      $display("FAIL frame_timeout w=%0d h=%0d beats=%0d exp=%0d", w, h, got, npix);
    end else if ({done, busy} !== 2'b10) begin
      bad++;
      $display("FAIL done_pulse w=%0d h=%0d got=%b exp=10", w, h, {done, busy});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({done, busy, out_valid, in_ready} !== 4'b0000) begin
      bad++;
      $display("FAIL idle_after w=%0d h=%0d got=%b exp=0000", w, h, {done, busy, out_valid, in_ready});
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({busy, done, cfg_err, in_ready, out_valid, out_data, out_sob, out_last_block} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=0", {busy, done, cfg_err, in_ready, out_valid, out_sob, out_last_block});
    end
    rst_ni = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({busy, in_ready, out_valid} !== 3'b000) begin
      bad++;
      $display("FAIL idle_after_reset got=%b exp=000", {busy, in_ready, out_valid});
    end
  endtask

  task automatic test_cfg_err();
    int ws [4];
    int hs [4];
    ws = '{0, 1, 33, 63};
    hs = '{1, 0, 2, 0};
    for (int i = 0; i < 4; i++) begin
      start_frame(ws[i], hs[i]);
      total++;
      if ({cfg_err, busy, in_ready} !== 3'b100) begin
        bad++;
        $display("FAIL cfg_err_pulse case=%0d got=%b exp=100", i, {cfg_err, busy, in_ready});
      end
      @(posedge clk); #1;
      total++;
      if ({cfg_err, busy, in_ready} !== 3'b000) begin
        bad++;
        $display("FAIL cfg_err_clear case=%0d got=%b exp=000", i, {cfg_err, busy, in_ready});
      end
    end
  endtask

  task automatic test_w1h1();
    int st;
    run_frame(1, 1, 24'h000000, 100, 1'b0, st);
  endtask

  task automatic test_w2h2();
    int st;
    run_frame(2, 2, 24'h000000, 100, 1'b0, st);
  endtask

  task automatic test_back_to_back();
    int st;
    run_frame(1, 1, 24'hA5A500, 100, 1'b0, st);
    run_frame(1, 1, 24'h3C0000, 100, 1'b0, st);
  endtask

  task automatic test_backpressure();
    int st;
    run_frame(2, 3, 24'h5A0000, 30, 1'b0, st);
    total++;
    if (st == 0) begin
      bad++;
      $display("FAIL backpressure_stall got=%0d exp=>0", st);
    end
  endtask

  task automatic test_max_width();
    int st;
    run_frame(32, 1, 24'hC30000, 100, 1'b0, st);
  endtask

  task automatic test_start_during_run();
    int st;
    run_frame(2, 2, 24'h0F0F00, 100, 1'b1, st);
  endtask

  task automatic test_midframe_reset();
    int acc = 0;
    int st;
    start_frame(2, 2);
    out_ready = 1'b0;
    for (int i = 0; i < 140; i++) begin
      in_valid = 1'b1;
      in_pixel = 24'hFFFFFF ^ 24'(acc);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_fill got=%b exp=1", out_valid);
    end
    rst_ni = 1'b0;
    #1;
    total++;
    if ({busy, done, cfg_err, in_ready, out_valid, out_data, out_sob, out_last_block} !== '0) begin
      bad++;
      $display("FAIL midframe_reset_outputs got=%b exp=0", {busy, done, cfg_err, in_ready, out_valid, out_sob, out_last_block});
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;
    run_frame(1, 1, 24'h123400, 100, 1'b0, st);
  endtask

  initial begin
    test_reset();
    test_cfg_err();
    test_w1h1();
    test_w2h2();
    test_back_to_back();
    test_backpressure();
    test_max_width();
    test_start_during_run();
    test_midframe_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
